// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM32 core fetch front end.
package cpu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // One stage of the instruction RAM read pipe.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } inflight_t;

    localparam int          IMEM_RD_LAT = 2;
    localparam logic [31:0] RESET_PC    = 32'h0;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Instruction RAM read port plus the valid/ready instruction stream to execute.
interface instr_fetch_queue_if #(
    parameter int ADDR_W = 11
);
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr_out;
    logic [31:0]       instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // master is the fetch unit; slave is the RAM plus the execute stage.
    modport master (
        output imem_rd, imem_addr, instr_out, instr_pc, instr_valid,
        input  imem_rdata, instr_ready
    );
    modport slave (
        input  imem_rd, imem_addr, instr_out, instr_pc, instr_valid,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue_fetch_buffer.sv
// Shift-register FIFO of fetched {pc, instr}; the head is always entry 0,
// so the head outputs come straight from flops.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 push_data,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  q [DEPTH];
    logic          do_pop;
    logic [IW-1:0] wr_idx;

    assign do_pop = pop && (count != '0);
    // Slot for the new entry after this cycle's shift; callers never push when full.
    assign wr_idx = IW'(count - CW'(do_pop));
    assign head   = q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset as well, so the head reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
            end
            if (push) q[wr_idx] <= push_data;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, issues reads to a 2-cycle instruction RAM
// and queues the returned words for execute; load_pc redirects and flushes.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_pc,
    input  logic [31:0]                  pc_in,
    instr_fetch_queue_if.master          bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [31:0]  pc;
    inflight_t    pipe [IMEM_RD_LAT];
    logic [SW-1:0] inflight_cnt;
    logic [SW-1:0] credit_used;
    logic         issue;
    logic         pop;
    fetch_entry_t head;

    always_comb begin
        // NOTE: blocking accumulation is correct here; this is combinational and starts from a default.
        inflight_cnt = '0;
        for (int i = 0; i < IMEM_RD_LAT; i++) inflight_cnt = inflight_cnt + SW'(pipe[i].valid);
    end

    // Reads in flight already own a queue slot, so the queue can never overflow.
    assign credit_used = SW'(count) + inflight_cnt;
    assign issue       = rst_n && !load_pc && (credit_used < SW'(DEPTH));

    assign bus.imem_rd     = issue;
    assign bus.imem_addr   = pc[ADDR_W+1:2];
    assign bus.instr_valid = (count != '0) && !load_pc;
    assign bus.instr_out   = head.instr;
    assign bus.instr_pc    = head.pc;
    assign pop             = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            for (int i = 0; i < IMEM_RD_LAT; i++) pipe[i] <= '0;
        end else if (load_pc) begin
            pc <= align_pc(pc_in);
            for (int i = 0; i < IMEM_RD_LAT; i++) pipe[i].valid <= 1'b0;
        end else begin
            if (issue) pc <= pc + 32'd4;
            pipe[0] <= '{valid: issue, pc: pc};
            for (int i = 1; i < IMEM_RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // The flush input wins over push, so a return landing with load_pc is dropped.
    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (load_pc),
        .push      (pipe[IMEM_RD_LAT-1].valid),
        .pop       (pop),
        .push_data ('{pc: pipe[IMEM_RD_LAT-1].pc, instr: bus.imem_rdata}),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: cycle tables, redirect/wrap/reset sequences,
// and a random run checked against a PC-stream reference model.
module tb_instr_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 11;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          load_pc = 1'b0;
    logic [31:0]   pc_in   = '0;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    instr_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_pc (load_pc),
        .pc_in   (pc_in),
        .bus     (bus),
        .count   (count)
    );

    always #5 clk = ~clk;

    // RAM contents: word k holds k + 100.
    function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
        return 32'(a) + 32'd100;
    endfunction

    // Two-cycle synchronous RAM; returns garbage when no read was issued.
    logic              ram_v1 = 1'b0;
    logic [ADDR_W-1:0] ram_a1 = '0;
    always @(posedge clk) begin
        ram_v1         <= bus.imem_rd;
        ram_a1         <= bus.imem_addr;
        bus.imem_rdata <= ram_v1 ? word(ram_a1) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit                ready;
        bit                rd;
        logic [ADDR_W-1:0] addr;
        bit                valid;
        logic [31:0]       pc;
        logic [31:0]       instr;
        int                cnt;
    } vec_t;

    vec_t stream_v[$];
    vec_t stall_v[$];

    function automatic vec_t mk(bit r, bit rd, int a, bit v, logic [31:0] p, logic [31:0] ins, int c);
        vec_t x;
        x.ready = r; x.rd = rd; x.addr = ADDR_W'(a); x.valid = v;
        x.pc = p; x.instr = ins; x.cnt = c;
        return x;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rdy, input bit ld, input logic [31:0] tgt);
        bus.instr_ready = rdy;
        load_pc         = ld;
        pc_in           = tgt;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int i);
        drive(v.ready, 1'b0, 32'h0);
        check($sformatf("%s[%0d].imem_rd", tag, i), 32'(bus.imem_rd), 32'(v.rd));
        check($sformatf("%s[%0d].imem_addr", tag, i), 32'(bus.imem_addr), 32'(v.addr));
        check($sformatf("%s[%0d].instr_valid", tag, i), 32'(bus.instr_valid), 32'(v.valid));
        check($sformatf("%s[%0d].instr_pc", tag, i), bus.instr_pc, v.pc);
        check($sformatf("%s[%0d].instr_out", tag, i), bus.instr_out, v.instr);
        check($sformatf("%s[%0d].count", tag, i), 32'(count), 32'(v.cnt));
        next_cycle();
    endtask

    // Entered just after a rising edge; leaves at the start of cycle 0 after release.
    task automatic do_reset(input int hold);
        rst_n           = 1'b0;
        load_pc         = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check("rst.imem_rd", 32'(bus.imem_rd), 32'h0);
        check("rst.instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst.instr_out", bus.instr_out, 32'h0);
        check("rst.instr_pc", bus.instr_pc, 32'h0);
        check("rst.count", 32'(count), 32'h0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          waited;
        bit          rdy, ld;
        logic [31:0] tgt;

        bus.instr_ready = 1'b1;

        // Free-running stream: first valid in cycle 3, then one per cycle.
        for (int c = 0; c < 8; c++)
            stream_v.push_back(mk(1'b1, 1'b1, c, c >= 3,
                                  (c < 3) ? 32'h0 : 32'(4 * (c - 3)),
                                  (c < 3) ? 32'h0 : 32'(100 + c - 3),
                                  (c < 3) ? 0 : 1));
        // Stall from reset: credit stops issue at 4, then release drains 100..103.
        stall_v.push_back(mk(0, 1, 0, 0, 32'd0,  32'd0,   0));
        stall_v.push_back(mk(0, 1, 1, 0, 32'd0,  32'd0,   0));
        stall_v.push_back(mk(0, 1, 2, 0, 32'd0,  32'd0,   0));
        stall_v.push_back(mk(0, 1, 3, 1, 32'd0,  32'd100, 1));
        stall_v.push_back(mk(0, 0, 4, 1, 32'd0,  32'd100, 2));
        stall_v.push_back(mk(0, 0, 4, 1, 32'd0,  32'd100, 3));
        stall_v.push_back(mk(0, 0, 4, 1, 32'd0,  32'd100, 4));
        stall_v.push_back(mk(1, 0, 4, 1, 32'd0,  32'd100, 4));
        stall_v.push_back(mk(1, 1, 4, 1, 32'd4,  32'd101, 3));
        stall_v.push_back(mk(1, 1, 5, 1, 32'd8,  32'd102, 2));
        stall_v.push_back(mk(1, 1, 6, 1, 32'd12, 32'd103, 1));
        stall_v.push_back(mk(1, 1, 7, 1, 32'd16, 32'd104, 1));

        #1;
        do_reset(2);
        foreach (stream_v[i]) run_vec(stream_v[i], "stream", i);

        do_reset(2);
        foreach (stall_v[i]) run_vec(stall_v[i], "stall", i);

        // Redirect to 0x40 with 2 queued and 2 reads in flight.
        do_reset(2);
        repeat (4) begin drive(1'b0, 1'b0, 32'h0); next_cycle(); end
        drive(1'b0, 1'b1, 32'h40);
        check("redir.count_before", 32'(count), 32'd2);
        check("redir.valid_in_N", 32'(bus.instr_valid), 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("redir.count_N1", 32'(count), 32'h0);
        check("redir.rd_N1", 32'(bus.imem_rd), 32'h1);
        check("redir.addr_N1", 32'(bus.imem_addr), 32'h10);
        next_cycle();
        for (int k = 2; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            check($sformatf("redir.valid_N%0d", k), 32'(bus.instr_valid), 32'h0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h0);
        check("redir.valid_N4", 32'(bus.instr_valid), 32'h1);
        check("redir.pc_N4", bus.instr_pc, 32'h40);
        check("redir.instr_N4", bus.instr_out, 32'd116);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("redir.pc_N5", bus.instr_pc, 32'h44);
        check("redir.instr_N5", bus.instr_out, 32'd117);
        next_cycle();

        // Back-to-back redirects: only the second target survives.
        drive(1'b1, 1'b1, 32'h80);
        check("b2b.valid_N", 32'(bus.instr_valid), 32'h0);
        check("b2b.rd_N", 32'(bus.imem_rd), 32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 32'hC0);
        check("b2b.valid_N1", 32'(bus.instr_valid), 32'h0);
        check("b2b.count_N1", 32'(count), 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("b2b.addr_N2", 32'(bus.imem_addr), 32'h30);
        for (int k = 2; k < 5; k++) begin
            if (k > 2) drive(1'b1, 1'b0, 32'h0);
            check($sformatf("b2b.valid_N%0d", k), 32'(bus.instr_valid), 32'h0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h0);
        check("b2b.pc_N5", bus.instr_pc, 32'hC0);
        check("b2b.instr_N5", bus.instr_out, 32'd148);
        next_cycle();

        // PC wrap at the top of the address space; low target bits ignored.
        drive(1'b1, 1'b1, 32'hFFFF_FFFF);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("wrap.addr_N1", 32'(bus.imem_addr), 32'h7FF);
        next_cycle();
        repeat (2) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end
        drive(1'b1, 1'b0, 32'h0);
        check("wrap.pc_N4", bus.instr_pc, 32'hFFFF_FFFC);
        check("wrap.instr_N4", bus.instr_out, 32'd2147);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("wrap.pc_N5", bus.instr_pc, 32'h0);
        check("wrap.instr_N5", bus.instr_out, 32'd100);
        next_cycle();

        // One-cycle reset mid-stream with reads outstanding, then a clean restart.
        do_reset(1);
        foreach (stream_v[i]) run_vec(stream_v[i], "restart", i);

        // Random ready/redirect traffic against the PC-stream model.
        do_reset(2);
        exp_pc = RESET_PC;
        for (int n = 0; n < 800; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 24) == 0);
            tgt = $urandom;
            drive(rdy, ld, tgt);
            if (ld) begin
                check("rnd.valid_on_load", 32'(bus.instr_valid), 32'h0);
                exp_pc = tgt & ~32'h3;
            end else if (bus.instr_valid && rdy) begin
                check("rnd.instr_pc", bus.instr_pc, exp_pc);
                check("rnd.instr_out", bus.instr_out, word(exp_pc[ADDR_W+1:2]));
                exp_pc = exp_pc + 32'd4;
            end
            if (count > CW'(DEPTH)) check("rnd.count_le_depth", 32'(count), 32'(DEPTH));
            next_cycle();
        end

        // Bounded wait for the stream to resume, then one instruction per cycle.
        waited = 0;
        drive(1'b1, 1'b0, 32'h0);
        while (!bus.instr_valid && waited < 20) begin
            next_cycle();
            drive(1'b1, 1'b0, 32'h0);
            waited++;
        end
        check("drain.valid_within_bound", 32'(bus.instr_valid), 32'h1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) drive(1'b1, 1'b0, 32'h0);
            check($sformatf("drain[%0d].valid", k), 32'(bus.instr_valid), 32'h1);
            check($sformatf("drain[%0d].pc", k), bus.instr_pc, exp_pc);
            check($sformatf("drain[%0d].instr", k), bus.instr_out, word(exp_pc[ADDR_W+1:2]));
            exp_pc = exp_pc + 32'd4;
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
